// File: rtl/usb_rx_packet_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared types and constants for the USB RX packet parser:
//                PID encodings, parser states, SYNC byte, CRC16 residual.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // 4-bit PID values as carried in the low nibble of the PID byte
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    // Parser states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_TOK1 = 3'd2,
        ST_TOK2 = 3'd3,
        ST_HSK  = 3'd4,
        ST_DATA = 3'd5,
        ST_ERR  = 3'd6
    } rx_state_t;

    localparam logic [7:0]  SYNC_BYTE      = 8'h80;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam int          MAX_DATA_BYTES = 64;

    // A PID byte is self-checking: upper nibble is the complement of the lower
    function automatic logic pid_check_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_packet_parser_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_crc16
//  Description : Byte-serial USB CRC16 (x^16+x^15+x^2+1), bits consumed
//                LSB first, register preset to all ones. Feeding payload
//                plus the transmitted CRC leaves a fixed residual.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_crc16 (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    localparam logic [15:0] c_POLY = 16'h8005;
    localparam logic [15:0] c_INIT = 16'hFFFF;

    logic [15:0] r_crc;
    logic [15:0] w_next;

    // Advance the CRC over the eight bits of one byte, LSB first
    always_comb begin
        w_next = r_crc;
        for (int i = 0; i < 8; i++) begin
            w_next = {w_next[14:0], 1'b0} ^ ({16{i_data[i] ^ w_next[15]}} & c_POLY);
        end
    end

    // CRC register: preset on clear, update on each enabled byte
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_crc <= c_INIT;
        end else if (i_clr) begin
            r_crc <= c_INIT;
        end else if (i_en) begin
            r_crc <= w_next;
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_rx_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_packet_parser
//  Description : Parses the decoded USB RX byte stream: SYNC/PID validation,
//                token address/endpoint extraction, DATA payload streaming
//                through a 2-byte holding pipe that withholds the CRC16.
//                Optional macro USB_RX_CRC16_CHECK_EN enables CRC16 checking
//                of DATA packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_packet_parser #(
    parameter int MAX_DATA_BYTES = usb_pkg::MAX_DATA_BYTES,
    parameter int OCC_W          = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_byte,
    input  logic             byte_valid,
    input  logic             eop,
    input  logic             rx_line_err,
    input  logic [OCC_W-1:0] Buffer_Occupancy,
    output logic [3:0]       rx_pid,
    output logic [6:0]       rx_addr,
    output logic [3:0]       rx_endp,
    output logic             Store_RX_Packet_Data,
    output logic [7:0]       RX_Packet_Data,
    output logic             rx_transfer_active,
    output logic             rx_packet_done,
    output logic             rx_data_ready,
    output logic             rx_error
);

    import usb_pkg::*;

    localparam int                   c_CNT_W      = $clog2(MAX_DATA_BYTES + 1);
    localparam logic [OCC_W-1:0]     c_OCC_LIMIT  = OCC_W'(MAX_DATA_BYTES);
    localparam logic [c_CNT_W-1:0]   c_PUSH_LIMIT = c_CNT_W'(MAX_DATA_BYTES);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);

    rx_state_t          r_state;
    logic [7:0]         r_hold0;       // oldest held DATA byte
    logic [7:0]         r_hold1;       // newest held DATA byte
    logic [1:0]         r_hold_cnt;
    logic [c_CNT_W-1:0] r_push_cnt;    // payload bytes written this packet
    logic               r_tok_b1_msb;  // endpoint bit 0 rides in token byte 1
    logic               r_tok2_seen;
    logic               w_sync_accept;
    logic               w_crc_ok;

    assign w_sync_accept = (r_state == ST_IDLE) && byte_valid && !eop && (rx_byte == SYNC_BYTE);

`ifdef USB_RX_CRC16_CHECK_EN
    logic        w_crc_en;
    logic [15:0] w_crc;

    assign w_crc_en = (r_state == ST_DATA) && byte_valid && !eop && !rx_line_err;

    usb_rx_crc16 u_crc16 (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (w_sync_accept),
        .i_en   (w_crc_en),
        .i_data (rx_byte),
        .o_crc  (w_crc)
    );

    assign w_crc_ok = (w_crc == CRC16_RESIDUAL);
`else
    assign w_crc_ok = 1'b1;
`endif

    // Packet FSM with registered outputs. Errors detected on the eop cycle
    // itself return straight to IDLE: the eop that ERR would wait for has
    // already been consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state              <= ST_IDLE;
            r_hold0              <= 8'h00;
            r_hold1              <= 8'h00;
            r_hold_cnt           <= 2'd0;
            r_push_cnt           <= '0;
            r_tok_b1_msb         <= 1'b0;
            r_tok2_seen          <= 1'b0;
            rx_pid               <= 4'h0;
            rx_addr              <= 7'h00;
            rx_endp              <= 4'h0;
            Store_RX_Packet_Data <= 1'b0;
            RX_Packet_Data       <= 8'h00;
            rx_transfer_active   <= 1'b0;
            rx_packet_done       <= 1'b0;
            rx_data_ready        <= 1'b0;
            rx_error             <= 1'b0;
        end else begin
            Store_RX_Packet_Data <= 1'b0;
            rx_packet_done       <= 1'b0;
            rx_data_ready        <= 1'b0;

            if (r_state == ST_IDLE) begin
                if (w_sync_accept) begin
                    r_state            <= ST_PID;
                    rx_transfer_active <= 1'b1;
                    rx_error           <= 1'b0;
                    r_hold_cnt         <= 2'd0;
                    r_push_cnt         <= '0;
                    r_tok2_seen        <= 1'b0;
                end
            end else if (r_state == ST_ERR) begin
                if (eop) begin
                    r_state            <= ST_IDLE;
                    rx_transfer_active <= 1'b0;
                end
            end else if (rx_line_err || (eop && byte_valid)) begin
                rx_error <= 1'b1;
                if (eop) begin
                    r_state            <= ST_IDLE;
                    rx_transfer_active <= 1'b0;
                end else begin
                    r_state <= ST_ERR;
                end
            end else if (eop) begin
                r_state            <= ST_IDLE;
                rx_transfer_active <= 1'b0;
                case (r_state)
                    ST_TOK2: begin
                        if (r_tok2_seen) rx_packet_done <= 1'b1;
                        else             rx_error       <= 1'b1;
                    end
                    ST_HSK: rx_packet_done <= 1'b1;
                    ST_DATA: begin
                        // The two held bytes are the CRC16 and are dropped
                        if (r_hold_cnt == 2'd2 && w_crc_ok) begin
                            rx_packet_done <= 1'b1;
                            rx_data_ready  <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                    default: rx_error <= 1'b1;
                endcase
            end else if (byte_valid) begin
                case (r_state)
                    ST_PID: begin
                        if (pid_check_ok(rx_byte)) begin
                            case (rx_byte[3:0])
                                PID_OUT, PID_IN, PID_SETUP: begin
                                    rx_pid  <= rx_byte[3:0];
                                    r_state <= ST_TOK1;
                                end
                                PID_ACK, PID_NAK, PID_STALL: begin
                                    rx_pid  <= rx_byte[3:0];
                                    r_state <= ST_HSK;
                                end
                                PID_DATA0, PID_DATA1: begin
                                    rx_pid  <= rx_byte[3:0];
                                    r_state <= ST_DATA;
                                end
                                default: begin
                                    rx_error <= 1'b1;
                                    r_state  <= ST_ERR;
                                end
                            endcase
                        end else begin
                            rx_error <= 1'b1;
                            r_state  <= ST_ERR;
                        end
                    end
                    ST_TOK1: begin
                        rx_addr      <= rx_byte[6:0];
                        r_tok_b1_msb <= rx_byte[7];
                        r_state      <= ST_TOK2;
                    end
                    ST_TOK2: begin
                        if (!r_tok2_seen) begin
                            rx_endp     <= {rx_byte[2:0], r_tok_b1_msb};
                            r_tok2_seen <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                            r_state  <= ST_ERR;
                        end
                    end
                    ST_DATA: begin
                        if (r_hold_cnt == 2'd2) begin
                            if (Buffer_Occupancy >= c_OCC_LIMIT || r_push_cnt == c_PUSH_LIMIT) begin
                                rx_error <= 1'b1;
                                r_state  <= ST_ERR;
                            end else begin
                                Store_RX_Packet_Data <= 1'b1;
                                RX_Packet_Data       <= r_hold0;
                                r_push_cnt           <= r_push_cnt + c_CNT_ONE;
                                r_hold0              <= r_hold1;
                                r_hold1              <= rx_byte;
                            end
                        end else begin
                            if (r_hold_cnt == 2'd0) r_hold0 <= rx_byte;
                            else                    r_hold1 <= rx_byte;
                            r_hold_cnt <= r_hold_cnt + 2'd1;
                        end
                    end
                    default: begin
                        rx_error <= 1'b1;
                        r_state  <= ST_ERR;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_rx_packet_parser
//  Description : Self-checking bench for usb_rx_packet_parser. Directed
//                packets followed by randomized ones; expected strobes are
//                queued by a packet-level model and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_packet_parser;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         kind;   // 0 = store, 1 = done pulse
        logic [7:0] val;
        bit         rdy;
    } ev_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       byte_valid = 1'b0;
    logic       eop = 1'b0;
    logic       rx_line_err = 1'b0;
    logic [6:0] Buffer_Occupancy = 7'd0;
    logic [3:0] rx_pid;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic       Store_RX_Packet_Data;
    logic [7:0] RX_Packet_Data;
    logic       rx_transfer_active;
    logic       rx_packet_done;
    logic       rx_data_ready;
    logic       rx_error;

    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    logic [3:0] m_pid  = 4'h0;
    logic [6:0] m_addr = 7'h00;
    logic [3:0] m_endp = 4'h0;
    logic       m_err  = 1'b0;

    usb_rx_packet_parser dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .rx_byte              (rx_byte),
        .byte_valid           (byte_valid),
        .eop                  (eop),
        .rx_line_err          (rx_line_err),
        .Buffer_Occupancy     (Buffer_Occupancy),
        .rx_pid               (rx_pid),
        .rx_addr              (rx_addr),
        .rx_endp              (rx_endp),
        .Store_RX_Packet_Data (Store_RX_Packet_Data),
        .RX_Packet_Data       (RX_Packet_Data),
        .rx_transfer_active   (rx_transfer_active),
        .rx_packet_done       (rx_packet_done),
        .rx_data_ready        (rx_data_ready),
        .rx_error             (rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [15:0] crc16_of(input bq_t d);
        logic [15:0] r = 16'hFFFF;
        foreach (d[k]) begin
            for (int i = 0; i < 8; i++) begin
                if (d[k][i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
                else                 r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // SYNC, PID, payload, CRC16 transmitted as complement, MSB of register first
    function automatic bq_t mk_data(input logic [7:0] pidb, input bq_t pay, input bit bad);
        bq_t         r;
        logic [15:0] c;
        c = crc16_of(pay);
        r = {8'h80, pidb};
        foreach (pay[i]) r.push_back(pay[i]);
        r.push_back(rev8(~c[15:8]));
        r.push_back(rev8(~c[7:0]) ^ (bad ? 8'h01 : 8'h00));
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    // Packet-level expectation: which strobes appear, final error and fields.
    // lerr = index of last byte sent before a line error (-1: none);
    // coll = last byte arrives together with eop.
    task automatic model(input bq_t p, input int occ, input int lerr, input bit coll, input bit crc_bad);
        int         nb = p.size();
        int         nproc;
        int         body;
        int         att;
        bit         forced;
        logic [3:0] pid;
        ev_t        e;
        nproc  = coll ? nb - 1 : ((lerr >= 0) ? lerr + 1 : nb);
        forced = coll || (lerr >= 0);
        m_err  = 1'b0;
        if (nproc < 2) begin m_err = 1'b1; return; end
        pid = p[1][3:0];
        if (p[1][7:4] != ~p[1][3:0]) begin m_err = 1'b1; return; end
        body = nproc - 2;
        e.val = 8'h00;
        if (pid inside {4'h1, 4'h9, 4'hD}) begin
            m_pid = pid;
            if (body >= 1) m_addr = p[2][6:0];
            if (body >= 2) m_endp = {p[3][2:0], p[2][7]};
            m_err = forced || (body != 2);
            if (!m_err) begin e.kind = 1; e.rdy = 1'b0; sb.push_back(e); end
        end else if (pid inside {4'h2, 4'hA, 4'hE}) begin
            m_pid = pid;
            m_err = forced || (body != 0);
            if (!m_err) begin e.kind = 1; e.rdy = 1'b0; sb.push_back(e); end
        end else if (pid inside {4'h3, 4'hB}) begin
            m_pid = pid;
            att = (body > 2) ? body - 2 : 0;
            if (occ >= 64 && att >= 1) begin
                m_err = 1'b1;
            end else begin
                if (att > 64) m_err = 1'b1;
                for (int j = 0; j < att && j < 64; j++) begin
                    e.kind = 0; e.val = p[2+j]; e.rdy = 1'b0; sb.push_back(e);
                end
`ifdef USB_RX_CRC16_CHECK_EN
                m_err = m_err || forced || (body < 2) || crc_bad;
`else
                m_err = m_err || forced || (body < 2);
`endif
                if (!m_err) begin e.kind = 1; e.val = 8'h00; e.rdy = 1'b1; sb.push_back(e); end
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_byte    = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rx_byte    = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic post_check();
        repeat (4) @(posedge clk);
        #1;
        chk("events_pending", sb.size(), 0);
        sb.delete();
        chk("rx_error", {31'd0, rx_error}, {31'd0, m_err});
        chk("pid_addr_endp", {17'd0, rx_pid, rx_addr, rx_endp}, {17'd0, m_pid, m_addr, m_endp});
        chk("transfer_active_idle", {31'd0, rx_transfer_active}, 32'd0);
    endtask

    task automatic run_pkt(input bq_t p, input int occ, input int lerr, input bit coll, input bit crc_bad);
        model(p, occ, lerr, coll, crc_bad);
        Buffer_Occupancy = 7'(occ);
        foreach (p[i]) begin
            if (coll && i == p.size() - 1) begin
                rx_byte = p[i]; byte_valid = 1'b1; eop = 1'b1;
                @(posedge clk); #1;
                byte_valid = 1'b0; eop = 1'b0;
            end else begin
                send_byte(p[i]);
                if (i == 1) chk("active_in_packet", {31'd0, rx_transfer_active}, 32'd1);
            end
            if (i == lerr) begin
                rx_line_err = 1'b1;
                @(posedge clk); #1;
                rx_line_err = 1'b0;
            end
        end
        if (!coll) begin
            eop = 1'b1;
            @(posedge clk); #1;
            eop = 1'b0;
        end
        post_check();
    endtask

    // ---------------- monitor ----------------
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (Store_RX_Packet_Data) begin
                checks++;
                if (sb.size() == 0 || sb[0].kind != 0) begin
                    errors++;
                    $display("FAIL store_event: got store of %0h, expected no store", RX_Packet_Data);
                end else begin
                    e = sb.pop_front();
                    if (RX_Packet_Data !== e.val) begin
                        errors++;
                        $display("FAIL store_data: got %0h, expected %0h", RX_Packet_Data, e.val);
                    end
                end
            end
            if (rx_packet_done || rx_data_ready) begin
                checks++;
                if (sb.size() == 0 || sb[0].kind != 1) begin
                    errors++;
                    $display("FAIL done_event: got done=%0b ready=%0b, expected no pulse", rx_packet_done, rx_data_ready);
                end else begin
                    e = sb.pop_front();
                    if (rx_packet_done !== 1'b1 || rx_data_ready !== e.rdy) begin
                        errors++;
                        $display("FAIL done_flags: got done=%0b ready=%0b, expected done=1 ready=%0b",
                                 rx_packet_done, rx_data_ready, e.rdy);
                    end
                end
            end
        end
    end

    // ---------------- main stimulus ----------------
    initial begin
        bq_t        pk;
        bq_t        pay;
        logic [7:0] tokp [3];
        logic [7:0] hskp [3];
        logic [7:0] datp [2];
        logic [7:0] b;
        int         n;
        tokp = '{8'hE1, 8'h69, 8'h2D};
        hskp = '{8'hD2, 8'h5A, 8'h1E};
        datp = '{8'hC3, 8'h4B};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {4'd0, rx_pid, rx_addr, rx_endp, Store_RX_Packet_Data, RX_Packet_Data,
                              rx_transfer_active, rx_packet_done, rx_data_ready, rx_error}, 32'd0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // OUT token addr 5 endp 0
        pk = {8'h80, 8'hE1, 8'h05, 8'hE8};
        run_pkt(pk, 0, -1, 1'b0, 1'b0);
        chk("token_fields", {17'd0, rx_pid, rx_addr, rx_endp}, {17'd0, 4'h1, 7'd5, 4'd0});
        // DATA0 with three payload bytes
        pay = {8'h11, 8'h22, 8'h33};
        run_pkt(mk_data(8'hC3, pay, 1'b0), 5, -1, 1'b0, 1'b0);
        // Zero-length DATA1
        pay = {};
        run_pkt(mk_data(8'h4B, pay, 1'b0), 0, -1, 1'b0, 1'b0);
        // ACK, then a PID that fails its check
        pk = {8'h80, 8'hD2};
        run_pkt(pk, 0, -1, 1'b0, 1'b0);
        pk = {8'h80, 8'hD3};
        run_pkt(pk, 0, -1, 1'b0, 1'b0);
        // Buffer already full
        pay = {8'h11, 8'h22, 8'h33};
        run_pkt(mk_data(8'hC3, pay, 1'b0), 64, -1, 1'b0, 1'b0);
        // Exactly the payload limit, then two beyond it
        run_pkt(mk_data(8'h4B, rand_bytes(64), 1'b0), 0, -1, 1'b0, 1'b0);
        run_pkt(mk_data(8'hC3, rand_bytes(66), 1'b0), 0, -1, 1'b0, 1'b0);
        // Byte and eop in the same cycle
        pk = {8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(pk, 0, -1, 1'b1, 1'b0);
        // Corrupted CRC (flagged only when CRC checking is built in)
        pay = {8'hA1, 8'hB2};
        run_pkt(mk_data(8'hC3, pay, 1'b1), 0, -1, 1'b0, 1'b1);

        // Reset in the middle of a DATA packet after two stores
        pk = mk_data(8'hC3, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b0);
        begin
            ev_t e;
            e.kind = 0; e.rdy = 1'b0;
            e.val = 8'h11; sb.push_back(e);
            e.val = 8'h22; sb.push_back(e);
        end
        Buffer_Occupancy = 7'd0;
        for (int i = 0; i < 6; i++) send_byte(pk[i]);
        @(negedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("midpacket_reset_outputs", {4'd0, rx_pid, rx_addr, rx_endp, Store_RX_Packet_Data, RX_Packet_Data,
                                        rx_transfer_active, rx_packet_done, rx_data_ready, rx_error}, 32'd0);
        chk("stores_before_reset", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        m_pid = 4'h0; m_addr = 7'h00; m_endp = 4'h0; m_err = 1'b0;
        @(posedge clk); #1;
        pk = {8'h80, 8'h69, 8'hA3, 8'h05};
        run_pkt(pk, 0, -1, 1'b0, 1'b0);

        // Randomized packets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = 8'($urandom);
                if (b == 8'h80) b = 8'h81;
                send_byte(b);
                rx_line_err = 1'b1;
                @(posedge clk); #1;
                rx_line_err = 1'b0;
            end
            case ($urandom_range(0, 9))
                0: begin
                    pk = {8'h80, tokp[$urandom_range(0, 2)], 8'($urandom), 8'($urandom)};
                    run_pkt(pk, 0, -1, 1'b0, 1'b0);
                end
                1: begin
                    n = $urandom_range(0, 2);
                    if (n == 2) n = 3;
                    pk = {8'h80, tokp[$urandom_range(0, 2)]};
                    for (int k = 0; k < n; k++) pk.push_back(8'($urandom));
                    run_pkt(pk, 0, -1, 1'b0, 1'b0);
                end
                2: begin
                    pk = {8'h80, hskp[$urandom_range(0, 2)]};
                    if ($urandom_range(0, 2) == 0) pk.push_back(8'($urandom));
                    run_pkt(pk, 0, -1, 1'b0, 1'b0);
                end
                3, 4, 5: begin
                    pk = mk_data(datp[$urandom_range(0, 1)], rand_bytes($urandom_range(0, 10)), 1'b0);
                    run_pkt(pk, $urandom_range(0, 63), -1, 1'b0, 1'b0);
                end
                6: begin
                    pk = {8'h80, datp[$urandom_range(0, 1)]};
                    if ($urandom_range(0, 1) == 1) pk.push_back(8'($urandom));
                    run_pkt(pk, 0, -1, 1'b0, 1'b0);
                end
                7: begin
                    case ($urandom_range(0, 2))
                        0: b = 8'hA5;
                        1: b = 8'h3C;
                        default: begin
                            b = 8'($urandom);
                            if (b[7:4] == ~b[3:0]) b[7] = ~b[7];
                        end
                    endcase
                    pk = {8'h80, b};
                    if ($urandom_range(0, 1) == 1) pk.push_back(8'($urandom));
                    run_pkt(pk, 0, -1, 1'b0, 1'b0);
                end
                8: begin
                    pk = mk_data(datp[$urandom_range(0, 1)], rand_bytes($urandom_range(0, 5)), 1'b0);
                    run_pkt(pk, $urandom_range(64, 127), -1, 1'b0, 1'b0);
                end
                default: begin
                    pk = mk_data(datp[$urandom_range(0, 1)], rand_bytes($urandom_range(0, 8)), 1'b0);
                    run_pkt(pk, $urandom_range(0, 63), $urandom_range(0, pk.size() - 1), 1'b0, 1'b0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
